// File: rtl/pq_pkg.sv
// Shared types and sizing for the register-array priority queue.
// The empty marker KEYINF is the all-ones key; a slot's valid bit is authoritative.
package pq_pkg;
  localparam int PQ_CAPACITY = 8;
  localparam int KEY_WIDTH   = 8;
  localparam int VAL_WIDTH   = 8;

  typedef struct packed {
    logic [KEY_WIDTH-1:0] key;
    logic [VAL_WIDTH-1:0] value;
  } kv_t;

  localparam logic [KEY_WIDTH-1:0] KEYINF   = {KEY_WIDTH{1'b1}};
  localparam kv_t                  KV_EMPTY = '{key: KEYINF, value: {VAL_WIDTH{1'b0}}};

  typedef enum logic [1:0] {OP_IDLE = 2'd0, OP_ENQ = 2'd1, OP_DEQ = 2'd2, OP_REP = 2'd3} op_e;
  typedef enum logic [1:0] {SEL_HOLD = 2'd0, SEL_LEFT = 2'd1, SEL_RIGHT = 2'd2, SEL_KVI = 2'd3} sel_e;
endpackage

// File: rtl/pq_if.sv
// Bus between a priority queue and its user; dev is the queue side, tb the driver side.
interface pq_if (input logic clk);
  import pq_pkg::*;
  logic rst_n;
  logic enq;
  logic deq;
  kv_t  kvi;
  kv_t  kvo;
  logic full;
  logic empty;
  logic busy;

  modport dev (input clk, rst_n, enq, deq, kvi, output kvo, full, empty, busy);
  modport tb  (input clk, kvo, full, empty, busy, output rst_n, enq, deq, kvi);
endinterface

// File: rtl/ra_pq_cell.sv
// One queue slot: key/value register, valid bit, and the shift/insert selection.
// o_gt means "this slot sits at or after the insert point for i_kvi".
module ra_pq_cell
  import pq_pkg::*;
#(
  parameter bit IS_HEAD = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  op_e  i_op,
  input  kv_t  i_kvi,
  input  kv_t  i_kv_left,
  input  logic i_valid_left,
  input  logic i_gt_left,
  input  kv_t  i_kv_right,
  input  logic i_valid_right,
  input  logic i_gt_right,
  output kv_t  o_kv,
  output logic o_valid,
  output logic o_gt
);
  kv_t  r_kv;
  logic r_valid;
  sel_e w_sel;
  kv_t  w_kv_nxt;
  logic w_valid_nxt;

  assign o_gt    = !r_valid || (r_kv.key > i_kvi.key);
  assign o_kv    = r_kv;
  assign o_valid = r_valid;

  // Replace: the head is leaving, so insertion is judged against the right neighbour.
  always_comb begin
    w_sel = SEL_HOLD;
    case (i_op)
      OP_ENQ: begin
        if (o_gt) begin
          w_sel = i_gt_left ? SEL_LEFT : SEL_KVI;
        end else begin
          w_sel = SEL_HOLD;
        end
      end
      OP_DEQ: w_sel = SEL_RIGHT;
      OP_REP: begin
        if (!i_gt_right) begin
          w_sel = SEL_RIGHT;
        end else if (IS_HEAD || !o_gt) begin
          w_sel = SEL_KVI;
        end else begin
          w_sel = SEL_HOLD;
        end
      end
      default: w_sel = SEL_HOLD;
    endcase
  end

  // Next-state mux for slot contents.
  always_comb begin
    w_kv_nxt    = r_kv;
    w_valid_nxt = r_valid;
    case (w_sel)
      SEL_LEFT: begin
        w_kv_nxt    = i_kv_left;
        w_valid_nxt = i_valid_left;
      end
      SEL_RIGHT: begin
        w_kv_nxt    = i_kv_right;
        w_valid_nxt = i_valid_right;
      end
      SEL_KVI: begin
        w_kv_nxt    = i_kvi;
        w_valid_nxt = 1'b1;
      end
      default: begin
        w_kv_nxt    = r_kv;
        w_valid_nxt = r_valid;
      end
    endcase
  end

  // Slot state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kv    <= KV_EMPTY;
      r_valid <= 1'b0;
    end else begin
      r_kv    <= w_kv_nxt;
      r_valid <= w_valid_nxt;
    end
  end
endmodule

// File: rtl/ra_pq_r.sv
// Register-array min priority queue: sorted slot chain with the minimum at slot 0.
// Enqueue, dequeue and replace each complete in a single clock edge.
module ra_pq_r
  import pq_pkg::*;
(
  pq_if.dev bus
);
  kv_t  w_kv    [PQ_CAPACITY];
  logic [PQ_CAPACITY-1:0] w_valid;
  logic [PQ_CAPACITY-1:0] w_gt;
  op_e  w_op;

  // Replace on an empty queue degenerates to enqueue; a full queue rejects plain enqueue.
  always_comb begin
    w_op = OP_IDLE;
    if (bus.enq && bus.deq && w_valid[0]) begin
      w_op = OP_REP;
    end else if (bus.enq && !w_valid[PQ_CAPACITY-1]) begin
      w_op = OP_ENQ;
    end else if (bus.deq && !bus.enq && w_valid[0]) begin
      w_op = OP_DEQ;
    end else begin
      w_op = OP_IDLE;
    end
  end

  for (genvar gi = 0; gi < PQ_CAPACITY; gi++) begin : g_cell
    kv_t  w_kv_left;
    logic w_valid_left;
    logic w_gt_left;
    kv_t  w_kv_right;
    logic w_valid_right;
    logic w_gt_right;

    if (gi == 0) begin : g_first
      assign w_kv_left    = KV_EMPTY;
      assign w_valid_left = 1'b0;
      assign w_gt_left    = 1'b0;
    end else begin : g_mid_l
      assign w_kv_left    = w_kv[gi-1];
      assign w_valid_left = w_valid[gi-1];
      assign w_gt_left    = w_gt[gi-1];
    end

    // Past the tail there is an implicit invalid slot.
    if (gi == PQ_CAPACITY-1) begin : g_last
      assign w_kv_right    = KV_EMPTY;
      assign w_valid_right = 1'b0;
      assign w_gt_right    = 1'b1;
    end else begin : g_mid_r
      assign w_kv_right    = w_kv[gi+1];
      assign w_valid_right = w_valid[gi+1];
      assign w_gt_right    = w_gt[gi+1];
    end

    ra_pq_cell #(.IS_HEAD(gi == 0)) u_cell (
      .i_clk        (bus.clk),
      .i_rst_n      (bus.rst_n),
      .i_op         (w_op),
      .i_kvi        (bus.kvi),
      .i_kv_left    (w_kv_left),
      .i_valid_left (w_valid_left),
      .i_gt_left    (w_gt_left),
      .i_kv_right   (w_kv_right),
      .i_valid_right(w_valid_right),
      .i_gt_right   (w_gt_right),
      .o_kv         (w_kv[gi]),
      .o_valid      (w_valid[gi]),
      .o_gt         (w_gt[gi])
    );
  end

  assign bus.kvo   = w_kv[0];
  assign bus.empty = !w_valid[0];
  assign bus.full  = w_valid[PQ_CAPACITY-1];
  assign bus.busy  = 1'b0;
endmodule

// File: tb/tb_ra_pq_r.sv
// Directed bench for ra_pq_r: a reference queue model predicts head/flags per step,
// predictions go through a scoreboard queue and are compared after each edge.
module tb_ra_pq_r;
  import pq_pkg::*;

  typedef struct packed {
    kv_t  head;
    logic empty;
    logic full;
  } exp_t;

  logic clk;
  pq_if u_if (.clk(clk));
  ra_pq_r dut (.bus(u_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  kv_t  mq [$];
  exp_t sb [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic mdl_ins(input kv_t kv);
    int p;
    p = mq.size();
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].key > kv.key) p = i;
    end
    mq.insert(p, kv);
  endtask

  function automatic exp_t mdl_state();
    exp_t e;
    e.head  = (mq.size() > 0) ? mq[0] : KV_EMPTY;
    e.empty = (mq.size() == 0);
    e.full  = (mq.size() == PQ_CAPACITY);
    return e;
  endfunction

  task automatic step(input string tag, input logic e, input logic d,
                      input logic [7:0] k, input logic [7:0] v);
    kv_t  kv;
    exp_t ex;
    kv = '{key: k, value: v};
    @(negedge clk);
    u_if.enq = e;
    u_if.deq = d;
    u_if.kvi = kv;
    if (e && d && mq.size() > 0) begin
      mq.delete(0);
      mdl_ins(kv);
    end else if (e && mq.size() < PQ_CAPACITY) begin
      mdl_ins(kv);
    end else if (d && !e && mq.size() > 0) begin
      mq.delete(0);
    end
    sb.push_back(mdl_state());
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    chk({tag, ".kvo"},   {16'd0, u_if.kvo}, {16'd0, ex.head});
    chk({tag, ".empty"}, {31'd0, u_if.empty}, {31'd0, ex.empty});
    chk({tag, ".full"},  {31'd0, u_if.full},  {31'd0, ex.full});
  endtask

  initial begin
    u_if.rst_n = 1'b0;
    u_if.enq   = 1'b0;
    u_if.deq   = 1'b0;
    u_if.kvi   = '0;
    repeat (2) @(negedge clk);
    u_if.rst_n = 1'b1;

    // reset state, idle
    step("idle", 1'b0, 1'b0, 8'h00, 8'h00);
    chk("idle.key", {24'd0, u_if.kvo.key}, 32'h0000_00FF);
    chk("idle.busy", {31'd0, u_if.busy}, 32'd0);

    // FIFO order on equal keys
    step("e5", 1'b1, 1'b0, 8'd5, 8'd1);
    step("e2", 1'b1, 1'b0, 8'd2, 8'd2);
    step("e9", 1'b1, 1'b0, 8'd9, 8'd3);
    step("e2b", 1'b1, 1'b0, 8'd2, 8'd7);
    chk("dup.val", {24'd0, u_if.kvo.value}, 32'd2);
    for (int i = 0; i < 4; i++) step("drain1", 1'b0, 1'b1, 8'd0, 8'd0);

    // fill descending, overflow ignored
    for (int i = 8; i >= 1; i--) step("fill", 1'b1, 1'b0, i[7:0], 8'h10 + i[7:0]);
    step("ovf", 1'b1, 1'b0, 8'd0, 8'hEE);
    chk("ovf.key", {24'd0, u_if.kvo.key}, 32'd1);

    // replace at full, then drain
    step("rep_full", 1'b1, 1'b1, 8'd4, 8'h44);
    chk("rep.key", {24'd0, u_if.kvo.key}, 32'd2);
    for (int i = 0; i < 8; i++) step("drain2", 1'b0, 1'b1, 8'd0, 8'd0);

    // empty boundaries
    step("deq_empty", 1'b0, 1'b1, 8'd0, 8'd0);
    step("rep_empty", 1'b1, 1'b1, 8'd3, 8'h33);
    step("ins_inf", 1'b1, 1'b0, 8'hFF, 8'h99);
    step("ins_7", 1'b1, 1'b0, 8'd7, 8'h77);
    step("pop", 1'b0, 1'b1, 8'd0, 8'd0);
    step("pop", 1'b0, 1'b1, 8'd0, 8'd0);
    chk("inf.valid", {31'd0, u_if.empty}, 32'd0);
    step("pop", 1'b0, 1'b1, 8'd0, 8'd0);

    // async reset mid-cycle while half full
    for (int i = 0; i < 4; i++) step("half", 1'b1, 1'b0, 8'd20 - i[7:0], 8'd0);
    @(negedge clk);
    u_if.enq = 1'b0;
    u_if.deq = 1'b0;
    #2;
    u_if.rst_n = 1'b0;
    #1;
    chk("arst.empty", {31'd0, u_if.empty}, 32'd1);
    chk("arst.full",  {31'd0, u_if.full},  32'd0);
    chk("arst.kvo",   {16'd0, u_if.kvo},   {16'd0, KV_EMPTY});
    mq.delete();
    @(negedge clk);
    u_if.rst_n = 1'b1;
    step("post_rst", 1'b1, 1'b0, 8'd42, 8'h24);
    step("post_rst2", 1'b1, 1'b0, 8'd10, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
